// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types for the instruction-memory program loader.
//   state_t    : loader FSM states
//   WORD_BYTES : bytes per instruction word (little-endian assembly)
package imem_loader_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      CSUM  = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

endpackage

// File: rtl/imem_loader_word_asm.sv
// imem_loader_word_asm
//   Collects WORD_BYTES stream bytes, LSB first, into one 32-bit word.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     clear      : drop any partial word (takes priority over byte_stb)
//     byte_stb   : byte_in is consumed this cycle
//     byte_in    : stream byte
//     word_full  : combinational pulse on the strobe that completes a word
//     word       : assembled word, valid while word_full is high
module imem_loader_word_asm
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_stb,
   input  logic [7:0]  byte_in,
   output logic        word_full,
   output logic [31:0] word
);

   localparam int CNT_W = $clog2(WORD_BYTES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      sh_q, sh_d;

   // New bytes enter at the top and slide down, so after four bytes the
   // first one received sits in bits [7:0].
   always_comb begin
      cnt_d = cnt_q;
      sh_d  = sh_q;
      if (clear) begin
         cnt_d = '0;
         sh_d  = '0;
      end else if (byte_stb) begin
         cnt_d = cnt_q + CNT_W'(1);
         sh_d  = {byte_in, sh_q[31:8]};
      end
   end

   assign word_full = byte_stb && !clear && (cnt_q == CNT_W'(WORD_BYTES - 1));
   assign word      = {byte_in, sh_q[31:8]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Writer side of the instruction memory. Consumes a byte stream
//   (header N, then 4*N payload bytes LSB first) and issues one memory write
//   per assembled word, holding the core in reset while the load runs.
//   Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256
//   checksum byte (sum of header and payload) before declaring success.
//   Ports:
//     clk, rst               : clock, asynchronous active-high reset
//     start                  : pulse that begins a load (ignored while busy)
//     byte_valid/byte_data   : input stream, transfer = byte_valid & byte_ready
//     byte_ready             : loader can take a byte this cycle
//     mem_we/addr/wdata      : instruction memory write port
//     cpu_hold               : keep the processor in reset
//     busy                   : load in progress
//     done / err             : sticky outcome of the last load
module imem_program_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic              byte_ready_q, byte_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [CNT_W-1:0]  tmo_q, tmo_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic        xfer;
   logic        start_acc;
   logic        hdr_ok;
   logic        asm_clear;
   logic        asm_stb;
   logic        word_full;
   logic [31:0] asm_word;

   assign xfer      = byte_valid && byte_ready_q;
   assign start_acc = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
   assign hdr_ok    = (byte_data != 8'd0) && (int'(byte_data) <= DEPTH);
   assign asm_clear = start_acc;
   assign asm_stb   = xfer && (state_q == DATA);

   imem_loader_word_asm u_word_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (asm_clear),
      .byte_stb  (asm_stb),
      .byte_in   (byte_data),
      .word_full (word_full),
      .word      (asm_word)
   );

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      last_addr_d = last_addr_q;
      tmo_d       = tmo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      // Idle watchdog for the byte-accepting states; a transfer in the
      // expiring cycle reloads instead of timing out.
      if (state_q == HDR || state_q == DATA || state_q == CSUM) begin
         if (xfer) begin
            tmo_d = CNT_W'(TIMEOUT);
         end else if (tmo_q <= CNT_W'(1)) begin
            state_d = ERR;
         end else begin
            tmo_d = tmo_q - CNT_W'(1);
         end
      end

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d    = HDR;
               mem_addr_d = '0;
               tmo_d      = CNT_W'(TIMEOUT);
            end
         end
         HDR: begin
            if (xfer) begin
               if (hdr_ok) begin
                  state_d     = DATA;
                  last_addr_d = ADDR_W'(byte_data - 8'd1);
               end else begin
                  state_d = ERR;
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = byte_data;
`endif
            end
         end
         DATA: begin
            if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q + byte_data;
`endif
               if (word_full) begin
                  state_d     = WRITE;
                  mem_wdata_d = asm_word;
               end
            end
         end
         WRITE: begin
            // Address parks on the last word rather than wrapping.
            if (mem_addr_q == last_addr_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = CSUM;
`else
               state_d = DONE;
`endif
            end else begin
               state_d    = DATA;
               mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
         end
         CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (xfer) state_d = (byte_data == csum_q) ? DONE : ERR;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered decodes of the next state.
      byte_ready_d = (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
      mem_we_d     = (state_d == WRITE);
      busy_d       = (state_d == HDR) || (state_d == DATA) ||
                     (state_d == WRITE) || (state_d == CSUM);
      cpu_hold_d   = busy_d || (state_d == ERR);
      done_d       = (state_d == DONE);
      err_d        = (state_d == ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         last_addr_q  <= '0;
         tmo_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         last_addr_q  <= last_addr_d;
         tmo_q        <= tmo_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign byte_ready = byte_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
